// File: rtl/led_seq_pkg.sv
// led_seq_pkg: shared definitions for the LED running-light sequencer.
//   mode_t        - display mode codes (SHIFT, PINGPONG, FILL, BLINK)
//   INIT_*        - pattern loaded into sel when a mode is entered
//   BLINK_ALT     - second phase of the blink pattern
//   init_pattern  - initial sel for a given mode
//   fill_pattern  - bar-graph pattern for fill count n, from bit 0 or bit 7
package led_seq_pkg;

    typedef enum logic [1:0] {
        MODE_SHIFT    = 2'd0,
        MODE_PINGPONG = 2'd1,
        MODE_FILL     = 2'd2,
        MODE_BLINK    = 2'd3
    } mode_t;

    localparam logic [7:0] INIT_SHIFT = 8'h01;
    localparam logic [7:0] INIT_FILL  = 8'h00;
    localparam logic [7:0] INIT_BLINK = 8'h55;
    localparam logic [7:0] BLINK_ALT  = 8'hAA;

    function automatic logic [7:0] init_pattern(input mode_t m);
        case (m)
            MODE_FILL:  return INIT_FILL;
            MODE_BLINK: return INIT_BLINK;
            default:    return INIT_SHIFT;  // ping-pong also starts at bit 0
        endcase
    endfunction

    // n in 0..8; fill_up=1 sets the n LSBs, fill_up=0 sets the n MSBs.
    function automatic logic [7:0] fill_pattern(input logic [3:0] n, input logic fill_up);
        logic [8:0] wide;
        logic [7:0] low;
        logic [7:0] rev;
        wide = (9'd1 << n) - 9'd1;
        low  = wide[7:0];
        for (int i = 0; i < 8; i++) begin
            rev[i] = low[7-i];
        end
        return fill_up ? low : rev;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce: synchronizer, debouncer and press-pulse generator for one
// active-low pushbutton.
//   clk_50MHz - board clock
//   rst       - asynchronous active-low reset
//   base_tick - one-cycle enable at the debounce sampling rate
//   key_raw   - raw active-low key, asynchronous to clk_50MHz
//   press     - one-cycle pulse when the debounced level goes 1->0
module key_debounce #(
    parameter int DEB_TICKS = 20
) (
    input  logic clk_50MHz,
    input  logic rst,
    input  logic base_tick,
    input  logic key_raw,
    output logic press
);

    localparam int CNT_W = $clog2(DEB_TICKS + 1);

    logic             sync_a;
    logic             sync_b;
    logic             level;
    logic [CNT_W-1:0] cnt;
    logic             accept;

    // The level flips on the DEB_TICKS-th consecutive disagreeing base tick.
    assign accept = base_tick && (sync_b != level) && (cnt == CNT_W'(DEB_TICKS - 1));

    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            sync_a <= 1'b1;
            sync_b <= 1'b1;
            level  <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync_a <= key_raw;
            sync_b <= sync_a;
            press  <= accept && level;
            if (base_tick) begin
                if (sync_b == level) begin
                    cnt <= '0;
                end else if (accept) begin
                    cnt   <= '0;
                    level <= sync_b;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/led_sequencer.sv
// led_sequencer: 8-LED pattern controller with four modes and four step rates.
//   clk_50MHz - board clock (only clock)
//   rst       - asynchronous active-low reset
//   key_mode  - raw active-low key, cycles the display mode
//   key_speed - raw active-low key, cycles the step rate
//   SW        - direction: 1 = toward bit 7, 0 = toward bit 0
//   sel       - LED pattern, active-high
//   mode      - current mode code
//   speed     - current speed code
//   step      - one-cycle pulse on each pattern step
module led_sequencer
    import led_seq_pkg::*;
#(
    parameter int BASE_DIV  = 50000,
    parameter int DEB_TICKS = 20,
    parameter int RATE0     = 1000,
    parameter int RATE1     = 500,
    parameter int RATE2     = 200,
    parameter int RATE3     = 100
) (
    input  logic       clk_50MHz,
    input  logic       rst,
    input  logic       key_mode,
    input  logic       key_speed,
    input  logic       SW,
    output logic [7:0] sel,
    output logic [1:0] mode,
    output logic [1:0] speed,
    output logic       step
);

    localparam int R01      = (RATE0 > RATE1) ? RATE0 : RATE1;
    localparam int R23      = (RATE2 > RATE3) ? RATE2 : RATE3;
    localparam int RATE_MAX = (R01 > R23) ? R01 : R23;
    localparam int PRE_W    = $clog2(BASE_DIV + 1);
    localparam int STEP_W   = $clog2(RATE_MAX + 1);

    logic [PRE_W-1:0]  pre_cnt;
    logic              base_tick;
    logic [STEP_W-1:0] step_cnt;
    logic [STEP_W-1:0] step_cnt_next;
    logic [STEP_W-1:0] rate_last;
    logic              step_hit;
    logic              sw_a;
    logic              sw_b;
    logic              mode_press;
    logic              speed_press;
    mode_t             mode_q;
    mode_t             mode_next;
    logic [1:0]        speed_next;
    logic [7:0]        sel_next;
    logic [3:0]        fill_n;
    logic [3:0]        fill_n_next;
    logic              dir_up;
    logic              dir_up_next;

    assign mode = mode_q;

    key_debounce #(.DEB_TICKS(DEB_TICKS)) u_key_mode (
        .clk_50MHz (clk_50MHz),
        .rst       (rst),
        .base_tick (base_tick),
        .key_raw   (key_mode),
        .press     (mode_press)
    );

    key_debounce #(.DEB_TICKS(DEB_TICKS)) u_key_speed (
        .clk_50MHz (clk_50MHz),
        .rst       (rst),
        .base_tick (base_tick),
        .key_raw   (key_speed),
        .press     (speed_press)
    );

    assign base_tick = (pre_cnt == PRE_W'(BASE_DIV - 1));

    always_comb begin
        case (speed)
            2'd0:    rate_last = STEP_W'(RATE0 - 1);
            2'd1:    rate_last = STEP_W'(RATE1 - 1);
            2'd2:    rate_last = STEP_W'(RATE2 - 1);
            default: rate_last = STEP_W'(RATE3 - 1);
        endcase
    end

    assign step_hit = base_tick && (step_cnt == rate_last);

    always_comb begin
        mode_next     = mode_q;
        speed_next    = speed;
        sel_next      = sel;
        fill_n_next   = fill_n;
        dir_up_next   = dir_up;
        step_cnt_next = step_cnt;

        if (base_tick) begin
            step_cnt_next = step_hit ? '0 : step_cnt + 1'b1;
        end
        // Any press restarts the step interval; a coincident step still fires.
        if (mode_press || speed_press) begin
            step_cnt_next = '0;
        end
        if (speed_press) begin
            speed_next = speed + 2'd1;
        end

        if (step_hit) begin
            case (mode_q)
                MODE_SHIFT: begin
                    sel_next = sw_b ? {sel[6:0], sel[7]} : {sel[0], sel[7:1]};
                end
                MODE_PINGPONG: begin
                    // Reverse on reaching an end so the end LED is lit for one step only.
                    if (dir_up) begin
                        if (sel[7]) begin
                            sel_next    = {1'b0, sel[7:1]};
                            dir_up_next = 1'b0;
                        end else begin
                            sel_next = {sel[6:0], 1'b0};
                        end
                    end else begin
                        if (sel[0]) begin
                            sel_next    = {sel[6:0], 1'b0};
                            dir_up_next = 1'b1;
                        end else begin
                            sel_next = {1'b0, sel[7:1]};
                        end
                    end
                end
                MODE_FILL: begin
                    fill_n_next = (fill_n == 4'd8) ? 4'd0 : fill_n + 4'd1;
                    sel_next    = fill_pattern(fill_n_next, sw_b);
                end
                default: begin
                    sel_next = (sel == INIT_BLINK) ? BLINK_ALT : INIT_BLINK;
                end
            endcase
        end

        // Mode change overrides whatever the step would have produced.
        if (mode_press) begin
            mode_next   = mode_t'(mode_q + 2'd1);
            sel_next    = init_pattern(mode_next);
            fill_n_next = 4'd0;
            dir_up_next = 1'b1;
        end
    end

    always_ff @(posedge clk_50MHz or negedge rst) begin
        if (!rst) begin
            pre_cnt  <= '0;
            step_cnt <= '0;
            sw_a     <= 1'b0;
            sw_b     <= 1'b0;
            mode_q   <= MODE_SHIFT;
            speed    <= 2'd0;
            sel      <= INIT_SHIFT;
            fill_n   <= 4'd0;
            dir_up   <= 1'b1;
            step     <= 1'b0;
        end else begin
            pre_cnt  <= base_tick ? '0 : pre_cnt + 1'b1;
            step_cnt <= step_cnt_next;
            sw_a     <= SW;
            sw_b     <= sw_a;
            mode_q   <= mode_next;
            speed    <= speed_next;
            sel      <= sel_next;
            fill_n   <= fill_n_next;
            dir_up   <= dir_up_next;
            step     <= step_hit;
        end
    end

endmodule
